// File: rtl/fp_pkg.sv
// Shared widths, FSM state and field layout for the 13-bit float to 8-bit
// integer converter.
package fp_pkg;
  localparam int FP_WIDTH   = 13;
  localparam int INT_WIDTH  = 8;
  localparam int EXP_WIDTH  = 4;
  localparam int MANT_WIDTH = 8;
  localparam int EXP_BIAS   = 7;
  localparam int SIG_WIDTH  = MANT_WIDTH + 1;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_SUB_ONE,
    CLS_SATURATE,
    CLS_NORMAL
  } fp_class_t;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exponent;
    logic [MANT_WIDTH-1:0] mantissa;
  } fp_t;
endpackage

// File: rtl/fp_int_conversion_unpack.sv
// Combinational field split and classification of an input float word.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [FP_WIDTH-1:0]   fp,
  output logic                  sign,
  output logic [MANT_WIDTH-1:0] mantissa,
  output logic [1:0]            fp_class,
  output logic [CNT_WIDTH-1:0]  shift_count
);
  fp_t       fields;
  fp_class_t cls;

  assign fields      = fp_t'(fp);
  assign sign        = fields.sign;
  assign mantissa    = fields.mantissa;
  assign fp_class    = cls;
  // Right shift that drops the fraction bits of {1,mant} for exponents 7..14.
  assign shift_count = CNT_WIDTH'(EXP_BIAS + MANT_WIDTH) - fields.exponent;

  always_comb begin
    cls = CLS_NORMAL;
    if (fields.exponent == '0 && fields.mantissa == '0) begin
      cls = CLS_ZERO;
    end else if (fields.exponent < EXP_WIDTH'(EXP_BIAS)) begin
      cls = CLS_SUB_ONE;
    end else if (fields.exponent == '1) begin
      cls = CLS_SATURATE;
    end else if (fields.exponent == EXP_WIDTH'(EXP_BIAS + MANT_WIDTH - 1)
                 && !(fields.sign && fields.mantissa == '0)) begin
      // Exponent 14 means magnitude >= 128; only exactly -128 still fits.
      cls = CLS_SATURATE;
    end
  end
endmodule

// File: rtl/fp_int_conversion.sv
// Handshaked float-to-integer converter: special cases resolve in one cycle,
// normal words are truncated by a serial right shifter.
module fp_int_conversion
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FP_WIDTH-1:0]  fp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WIDTH-1:0] signed_int,
  output logic                 overflow,
  output logic                 inexact
);
  state_t                state_reg, state_next;
  logic [SIG_WIDTH-1:0]  sig_reg, sig_next;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic                  sign_reg, sign_next;
  logic                  sticky_reg, sticky_next;
  logic [INT_WIDTH-1:0]  result_reg, result_next;
  logic                  overflow_reg, overflow_next;
  logic                  inexact_reg, inexact_next;

  logic                  fp_sign;
  logic [MANT_WIDTH-1:0] fp_mant;
  logic [1:0]            fp_cls;
  logic [CNT_WIDTH-1:0]  fp_shift;
  logic [SIG_WIDTH-1:0]  sig_shifted;

  fp_unpack u_unpack (
    .fp          (fp),
    .sign        (fp_sign),
    .mantissa    (fp_mant),
    .fp_class    (fp_cls),
    .shift_count (fp_shift)
  );

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign signed_int  = result_reg;
  assign overflow    = overflow_reg;
  assign inexact     = inexact_reg;
  assign sig_shifted = {1'b0, sig_reg[SIG_WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sig_reg      <= '0;
      count_reg    <= '0;
      sign_reg     <= 1'b0;
      sticky_reg   <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      inexact_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sig_reg      <= sig_next;
      count_reg    <= count_next;
      sign_reg     <= sign_next;
      sticky_reg   <= sticky_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      inexact_reg  <= inexact_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sig_next      = sig_reg;
    count_next    = count_reg;
    sign_next     = sign_reg;
    sticky_next   = sticky_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    inexact_next  = inexact_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          case (fp_class_t'(fp_cls))
            CLS_ZERO: begin
              result_next   = '0;
              overflow_next = 1'b0;
              inexact_next  = 1'b0;
              state_next    = DONE;
            end
            CLS_SUB_ONE: begin
              result_next   = '0;
              overflow_next = 1'b0;
              inexact_next  = 1'b1;
              state_next    = DONE;
            end
            CLS_SATURATE: begin
              result_next   = fp_sign ? 8'h80 : 8'h7F;
              overflow_next = 1'b1;
              inexact_next  = 1'b0;
              state_next    = DONE;
            end
            default: begin
              // Output registers keep the previous result until this one is ready.
              sig_next    = {1'b1, fp_mant};
              count_next  = fp_shift;
              sign_next   = fp_sign;
              sticky_next = 1'b0;
              state_next  = SHIFT;
            end
          endcase
        end
      end
      SHIFT: begin
        sig_next    = sig_shifted;
        sticky_next = sticky_reg | sig_reg[0];
        count_next  = count_reg - CNT_WIDTH'(1);
        if (count_reg == CNT_WIDTH'(1)) begin
          result_next   = sign_reg ? (~sig_shifted[INT_WIDTH-1:0] + INT_WIDTH'(1))
                                   : sig_shifted[INT_WIDTH-1:0];
          overflow_next = 1'b0;
          inexact_next  = sticky_reg | sig_reg[0];
          state_next    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_fp_int_conversion.sv
// Randomized and directed bench for fp_int_conversion with a value-level
// reference model and a per-cycle scoreboard.
module tb_fp_int_conversion;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] fp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  signed_int;
  logic        overflow;
  logic        inexact;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  bit started  = 0;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       inex;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];

  fp_int_conversion dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fp         (fp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .signed_int (signed_int),
    .overflow   (overflow),
    .inexact    (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, req, req, $time);
  endtask

  // Real value is (256+mant) / 2^(15-exp); truncate toward zero, saturate
  // when the exact value lies outside [-128, 127].
  function automatic exp_t model(input logic [12:0] w);
    exp_t e;
    int   s, ex, full, sh, mag;
    bit   frac;
    s    = int'(w[12]);
    ex   = int'(w[11:8]);
    full = 256 + int'(w[7:0]);
    e.acc = 0;
    if (ex == 0 && w[7:0] == 8'h00) begin
      e.res = 8'h00; e.ovf = 0; e.inex = 0; e.lat = 1;
      return e;
    end
    sh   = 15 - ex;
    mag  = full >> sh;
    frac = (full % (1 << sh)) != 0;
    if (s == 0 && mag > 127) begin
      e.res = 8'h7F; e.ovf = 1; e.inex = 0; e.lat = 1;
    end else if (s == 1 && (mag > 128 || (mag == 128 && frac))) begin
      e.res = 8'h80; e.ovf = 1; e.inex = 0; e.lat = 1;
    end else begin
      e.res  = s ? 8'(-mag) : 8'(mag);
      e.ovf  = 0;
      e.inex = frac;
      e.lat  = (ex < 7) ? 1 : sh + 1;
    end
    return e;
  endfunction

  // Scoreboard bookkeeping at the active edge (sees pre-edge values).
  always @(posedge clk) begin
    exp_t e;
    edge_cnt++;
    if (!rst) begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(fp);
        e.acc = edge_cnt;
        q.push_back(e);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int lat;
    if (!rst && started) begin
      chk("in_ready", int'(in_ready), int'(q.size() == 0));
      if (q.size() == 0) begin
        chk("out_valid_idle", int'(out_valid), 0);
      end else begin
        lat = edge_cnt - q[0].acc + 1;
        chk("out_valid_latency", int'(out_valid), int'(lat >= q[0].lat));
        if (out_valid && lat >= q[0].lat) begin
          chk("signed_int", int'(signed_int), int'(q[0].res));
          chk("overflow", int'(overflow), int'(q[0].ovf));
          chk("inexact", int'(inexact), int'(q[0].inex));
        end
      end
    end
  end

  task automatic xfer(input logic [12:0] w, input int hold);
    int t;
    @(negedge clk);
    fp = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fp = 13'($urandom);
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [12:0] w;
    logic [7:0]  res;
    logic        ovf;
    logic        inex;
    int          lat;
  } vec_t;

  vec_t dir[12] = '{
    '{13'h0000, 8'h00, 1'b0, 1'b0, 1},
    '{13'h0940, 8'h05, 1'b0, 1'b0, 7},
    '{13'h1940, 8'hFB, 1'b0, 1'b0, 7},
    '{13'h0840, 8'h02, 1'b0, 1'b1, 8},
    '{13'h1E00, 8'h80, 1'b0, 1'b0, 2},
    '{13'h0E00, 8'h7F, 1'b1, 1'b0, 1},
    '{13'h1F55, 8'h80, 1'b1, 1'b0, 1},
    '{13'h0355, 8'h00, 1'b0, 1'b1, 1},
    '{13'h1E01, 8'h80, 1'b1, 1'b0, 1},
    '{13'h0700, 8'h01, 1'b0, 1'b0, 9},
    '{13'h1780, 8'hFF, 1'b0, 1'b1, 9},
    '{13'h1840, 8'hFE, 1'b0, 1'b1, 8}
  };

  initial begin
    exp_t m;
    #3;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_signed_int", int'(signed_int), 0);
    chk("reset_flags", int'({overflow, inexact}), 0);
    @(negedge clk);
    rst = 1'b0;
    started = 1;

    foreach (dir[i]) begin
      m = model(dir[i].w);
      chk("model_res", int'(m.res), int'(dir[i].res));
      chk("model_flags", int'({m.ovf, m.inex}), int'({dir[i].ovf, dir[i].inex}));
      chk("model_lat", m.lat, dir[i].lat);
      xfer(dir[i].w, (i == 1) ? 3 : 0);
      $display("dir  fp=%h -> int=%h ovf=%0d inex=%0d", dir[i].w, signed_int, overflow, inexact);
    end

    // Abandon a conversion during its third shift cycle.
    @(negedge clk);
    fp = 13'h0940;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_signed_int", int'(signed_int), 0);
    chk("rst_flags", int'({overflow, inexact}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    $display("rst  abandoned fp=0940, out_valid=%0d", out_valid);

    for (int n = 0; n < 300; n++) begin
      logic [12:0] w;
      w = 13'($urandom);
      if (n % 3 == 0) w[11:8] = 4'($urandom_range(6, 15));
      xfer(w, $urandom_range(0, 3));
      $display("rand fp=%h -> int=%h ovf=%0d inex=%0d", w, signed_int, overflow, inexact);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_int_conversion.md
FP_INT_CONVERSION -- requirements
Module: fp_int_conversion

Interface
REQ-001 Parameters: none; all widths come from the shared package (FP_WIDTH=13, INT_WIDTH=8, EXP_BIAS=7).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 in_valid  in  1  fp holds a word to convert.
REQ-005 in_ready  out  1  block can accept; high only in IDLE.
REQ-006 fp  in  13  {sign[12], exponent[11:8] biased by 7, mantissa[7:0] fraction bits below an implicit leading 1}.
REQ-007 out_valid  out  1  signed_int and flags are valid.
REQ-008 out_ready  in  1  consumer accepts the result.
REQ-009 signed_int  out  8  two's-complement result.
REQ-010 overflow  out  1  result was saturated.
REQ-011 inexact  out  1  nonzero fraction bits were discarded.

Function
REQ-012 Input transfer occurs on an edge where in_valid and in_ready are both high; output transfer occurs on an edge where out_valid and out_ready are both high.
REQ-013 FSM states: IDLE, SHIFT, DONE; in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014 IDLE on accept, zero word (exp=0 and mant=0, either sign): go to DONE with result 0 and both flags 0.
REQ-015 IDLE on accept, exp<7 (nonzero word): go to DONE with result 0, inexact=1, overflow=0.
REQ-016 IDLE on accept, exp=15, or exp=14 with magnitude {1,mant}>>1 > 127: go to DONE saturated.
  - Positive saturates to 127; negative saturates to -128 (8'h80).
  - overflow=1, inexact=0.
  - Exception: negative with exp=14 and mant=0 equals exactly -128 and is not saturated.
REQ-017 IDLE on accept, otherwise: load 9-bit sig={1,mant}, load count k=15-exp (range 1..8), load sign, clear sticky inexact, then go to SHIFT.
REQ-018 SHIFT: each cycle does sig>>=1, inexact|=sig[0] (bit shifted out), count-=1; after exactly k SHIFT cycles go to DONE.
REQ-019 On SHIFT->DONE, register signed_int = sign ? -sig[7:0] : sig[7:0]; -128 is formed from sig=128 (8'h80).
REQ-020 Latency from the accepting edge:
  - Special cases (REQ-014..016): out_valid in the next cycle (1 cycle).
  - Normal case: out_valid in cycle k+1.
REQ-021 DONE: signed_int, overflow and inexact are held stable while out_ready=0; on output transfer go to IDLE.
REQ-022 DONE->IDLE->accept costs one IDLE cycle; no input is accepted in DONE (no bypass).
REQ-023 Rounding is truncation toward zero.
REQ-024 signed_int and the flags keep their last values outside DONE.
REQ-025 fp is sampled only on the accepting edge; later changes to fp do not affect the result.

Reset
REQ-026 rst forces, immediately and asynchronously: state=IDLE, in_ready=1, out_valid=0, signed_int=0, overflow=0, inexact=0, count=0, sig=0.
REQ-027 Reset during SHIFT or DONE abandons the conversion; no out_valid follows for that word.

Structure
REQ-028 Shared package fp_pkg holds: FP_WIDTH, INT_WIDTH, EXP_WIDTH=4, MANT_WIDTH=8, EXP_BIAS=7, the state enum, and packed struct fp_t {sign, exponent, mantissa}.
REQ-029 One combinational sub-module, fp_unpack, splits fp into fields and classifies it as zero / sub-one / saturate / normal; the FSM, shifter and negation stay in fp_int_conversion.

Verification
REQ-030 fp=13'h0000 -> signed_int=0, flags 0, out_valid 1 cycle after accept.
REQ-031 fp=13'h0940 (5.0) -> signed_int=5, inexact 0, latency 7; fp=13'h1940 -> 8'hFB.
REQ-032 fp=13'h0840 (2.5) -> 2, inexact 1, latency 8; fp=13'h1840 -> 8'hFE, inexact 1.
REQ-033 Boundary values:
  - fp=13'h1E00 -> 8'h80, overflow 0, latency 2.
  - fp=13'h0E00 -> 8'h7F, overflow 1, latency 1.
  - fp=13'h1F55 -> 8'h80, overflow 1.
  - fp=13'h0355 -> 0, inexact 1.
REQ-034 Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0; the next word is accepted only after the transfer plus one IDLE cycle.
REQ-035 Assert rst in the 3rd SHIFT cycle of 13'h0940 -> immediate IDLE, all outputs 0, no out_valid until a new word is accepted.
